// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE,
        SHIFT
    } piso_state_t;

    // Bit counter width: enough to hold WIDTH-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return ($clog2(width) < 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/piso_tx_if.sv
// Producer-side load handshake plus serial output bundle for piso_tx.
interface piso_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             en;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic             sdo;
    logic             sdo_valid;
    logic             busy;
    logic             done;

    // Producer / link controller side.
    modport master (
        output en, load_valid, load_data,
        input  load_ready, sdo, sdo_valid, busy, done
    );

    // Transmitter side.
    modport slave (
        input  en, load_valid, load_data,
        output load_ready, sdo, sdo_valid, busy, done
    );
endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter tracking how many bits remain after the one on sdo.
module piso_bit_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt_q;

    // Load has priority; the FSM never decrements at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter: takes a word on valid/ready and emits it
// one bit per en strobe, pulsing done once the last bit has been consumed.
module piso_tx
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    piso_tx_if.slave  bus
);
    localparam int unsigned      CntW    = cnt_w(WIDTH);
    localparam logic [CntW-1:0]  LastIdx = CntW'(WIDTH - 1);

    piso_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             done_q, done_d;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic             accept;

    assign accept = bus.load_valid && (state_q == IDLE);

    piso_bit_counter #(
        .CNT_W (CntW)
    ) u_bit_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (LastIdx),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State, shift register and done pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    // Next-state: load on accept, shift toward the output end on each en strobe.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    shreg_d  = bus.load_data;
                    cnt_load = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.en) begin
                    if (cnt_zero) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                        cnt_dec = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are pure decodes of the registered state.
    always_comb begin
        bus.load_ready = (state_q == IDLE);
        bus.busy       = (state_q == SHIFT);
        bus.sdo_valid  = (state_q == SHIFT);
        bus.done       = done_q;
        bus.sdo        = 1'b0;
        if (state_q == SHIFT) begin
            bus.sdo = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end
endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: three instances (8-bit MSB-first, 8-bit
// LSB-first, 1-bit) share clock, reset and stimulus; sel picks the active one.
module tb_piso_tx;
    logic       clk = 1'b0;
    logic       reset_n;
    int         sel;
    logic       lv, en;
    logic [7:0] data;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(8)) bus_m ();
    piso_tx_if #(.WIDTH(8)) bus_l ();
    piso_tx_if #(.WIDTH(1)) bus_1 ();

    assign bus_m.en         = en && (sel == 0);
    assign bus_m.load_valid = lv && (sel == 0);
    assign bus_m.load_data  = data;
    assign bus_l.en         = en && (sel == 1);
    assign bus_l.load_valid = lv && (sel == 1);
    assign bus_l.load_data  = data;
    assign bus_1.en         = en && (sel == 2);
    assign bus_1.load_valid = lv && (sel == 2);
    assign bus_1.load_data  = data[0];

    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset_n(reset_n), .bus(bus_m));
    piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(bus_l));
    piso_tx #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_1 (.clk(clk), .reset_n(reset_n), .bus(bus_1));

    logic o_sdo, o_vld, o_busy, o_done, o_rdy;
    assign o_sdo  = (sel == 0) ? bus_m.sdo        : (sel == 1) ? bus_l.sdo        : bus_1.sdo;
    assign o_vld  = (sel == 0) ? bus_m.sdo_valid  : (sel == 1) ? bus_l.sdo_valid  : bus_1.sdo_valid;
    assign o_busy = (sel == 0) ? bus_m.busy       : (sel == 1) ? bus_l.busy       : bus_1.busy;
    assign o_done = (sel == 0) ? bus_m.done       : (sel == 1) ? bus_l.done       : bus_1.done;
    assign o_rdy  = (sel == 0) ? bus_m.load_ready : (sel == 1) ? bus_l.load_ready : bus_1.load_ready;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (sel=%0d t=%0t): got %b expected %b", name, sel, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word: accept, then each bit held for 'period' cycles with en on the last.
    // exp holds the bits in transmission order, exp[7] first.
    task automatic run_word(input int s, input logic [7:0] d, input int period,
                            input logic [7:0] exp);
        sel = s;
        lv  = 1'b1;
        data = d;
        en  = 1'b0;
        #1;
        check("idle_ready", o_rdy, 1'b1);
        check("idle_vld", o_vld, 1'b0);
        tick();
        lv = 1'b0;
        data = 8'hXX;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < period; j++) begin
                check("bit_sdo", o_sdo, exp[7-k]);
                check("bit_vld", o_vld, 1'b1);
                check("bit_busy", o_busy, 1'b1);
                check("bit_ready", o_rdy, 1'b0);
                check("bit_nodone", o_done, 1'b0);
                en = (j == period - 1);
                tick();
            end
        end
        en = 1'b0;
        check("done_hi", o_done, 1'b1);
        check("done_busy", o_busy, 1'b0);
        check("done_vld", o_vld, 1'b0);
        check("done_sdo", o_sdo, 1'b0);
        check("done_ready", o_rdy, 1'b1);
        tick();
        check("done_lo", o_done, 1'b0);
    endtask

    typedef struct {
        int         s;
        logic [7:0] d;
        int         period;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{s: 0, d: 8'hA5, period: 1, exp: 8'b10100101};
        vecs[1] = '{s: 0, d: 8'hC3, period: 3, exp: 8'b11000011};
        vecs[2] = '{s: 1, d: 8'h01, period: 1, exp: 8'b10000000};
        vecs[3] = '{s: 1, d: 8'hB4, period: 2, exp: 8'b00101101};

        sel = 0; lv = 1'b0; en = 1'b0; data = 8'h00;
        reset_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check("rst_ready", o_rdy, 1'b1);
            check("rst_sdo", o_sdo, 1'b0);
            check("rst_vld", o_vld, 1'b0);
            check("rst_busy", o_busy, 1'b0);
            check("rst_done", o_done, 1'b0);
        end
        #7 reset_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_word(vecs[i].s, vecs[i].d, vecs[i].period, vecs[i].exp);
        end

        // Back-to-back: 8'hFF offered all through 8'h3C, taken in the done cycle.
        begin
            logic [7:0] seq;
            sel = 0; data = 8'h3C; lv = 1'b1; en = 1'b1;
            tick();
            data = 8'hFF;
            seq = 8'b00111100;
            for (int k = 0; k < 8; k++) begin
                check("b2b_ready", o_rdy, 1'b0);
                check("b2b_sdo", o_sdo, seq[7-k]);
                tick();
            end
            check("b2b_done", o_done, 1'b1);
            check("b2b_ready_done", o_rdy, 1'b1);
            tick();
            lv = 1'b0;
            check("b2b_done_lo", o_done, 1'b0);
            check("b2b_busy2", o_busy, 1'b1);
            for (int k = 0; k < 8; k++) begin
                check("b2b_ff_sdo", o_sdo, 1'b1);
                tick();
            end
            en = 1'b0;
            check("b2b_ff_done", o_done, 1'b1);
            tick();
        end

        // Asynchronous reset after three bits of 8'hF0.
        sel = 0; data = 8'hF0; lv = 1'b1; en = 1'b1;
        tick();
        lv = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_busy", o_busy, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_sdo", o_sdo, 1'b0);
        check("arst_busy", o_busy, 1'b0);
        check("arst_vld", o_vld, 1'b0);
        check("arst_done", o_done, 1'b0);
        en = 1'b0;
        #2 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("post_rst_nodone", o_done, 1'b0);
            check("post_rst_idle", o_rdy, 1'b1);
        end
        run_word(0, 8'h81, 1, 8'b10000001);

        // WIDTH=1: bit held through four idle strobes, done after the en edge.
        sel = 2; data = 8'h01; lv = 1'b1; en = 1'b0;
        tick();
        lv = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("w1_sdo", o_sdo, 1'b1);
            check("w1_busy", o_busy, 1'b1);
            check("w1_nodone", o_done, 1'b0);
            en = (c == 4);
            tick();
        end
        en = 1'b0;
        check("w1_done", o_done, 1'b1);
        check("w1_idle", o_busy, 1'b0);
        tick();
        check("w1_done_lo", o_done, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
